// File: rtl/prog_ctr_ret_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Base() gives the untruncated program start address.
package prog_ctr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN,
      DONE
   } state_t;

   localparam int DEF_PC_W        = 10;
   localparam int DEF_STACK_DEPTH = 4;
   localparam int DEF_NUM_PROGS   = 4;
   localparam int DEF_PROG_STRIDE = 256;

   function automatic int unsigned Base(
      input int unsigned n,
      input int unsigned stride
   );
      return n * stride;
   endfunction

endpackage

// File: rtl/prog_ctr_ret_if.sv
// Control/status bundle between decode/execute and the PC.
// slave = program counter, master = its driver.
interface prog_ctr_ret_if
   import prog_ctr_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int SEL_W = $clog2(DEF_NUM_PROGS)
);
   logic             Start;
   logic [SEL_W-1:0] ProgSel;
   logic             BranchAbsEn;
   logic             BranchRelEn;
   logic             ALU_flag;
   logic             Call;
   logic             Ret;
   logic             Stall;
   logic             Halt;
   logic [PC_W-1:0]  TargetOrOffset;
   logic [PC_W-1:0]  PC;
   logic             Running;
   logic             Done;
   logic             StackErr;

   modport master (
      output Start, ProgSel, BranchAbsEn, BranchRelEn,
      output ALU_flag, Call, Ret, Stall, Halt,
      output TargetOrOffset,
      input  PC, Running, Done, StackErr
   );

   modport slave (
      input  Start, ProgSel, BranchAbsEn, BranchRelEn,
      input  ALU_flag, Call, Ret, Stall, Halt,
      input  TargetOrOffset,
      output PC, Running, Done, StackErr
   );
endinterface

// File: rtl/prog_ctr_ret_stack.sv
// Bounded LIFO of return addresses; push-when-full and
// pop-when-empty are dropped here, parent sees full/empty.
module ret_stack #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         Clk,
   input  logic         push,
   input  logic         pop,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] topIdx;

   assign full   = (ptr == PW'(DEPTH));
   assign empty  = (ptr == '0);
   assign topIdx = ptr - PW'(1);
   assign dout   = mem[topIdx[IW-1:0]];

   always_ff @(posedge Clk) begin
      if (clr) begin
         ptr <= '0;
      end else if (push && !full) begin
         mem[ptr[IW-1:0]] <= din;
         ptr              <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end
endmodule

// File: rtl/prog_ctr_ret.sv
// Fetch-stage program counter with program select, branches,
// call/return via a hardware stack, stall and halt.
module prog_ctr_ret
   import prog_ctr_pkg::*;
#(
   parameter int PC_W        = DEF_PC_W,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH,
   parameter int NUM_PROGS   = DEF_NUM_PROGS,
   parameter int PROG_STRIDE = DEF_PROG_STRIDE
) (
   input  logic         Clk,
   input  logic         Reset,
   prog_ctr_ret_if.slave Bus
);
   state_t          state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pcInc;
   logic [PC_W-1:0] baseAddr;
   logic [PC_W-1:0] stkTop;
   logic            running;
   logic            done;
   logic            stackErr;
   logic            stkFull;
   logic            stkEmpty;
   logic            stkPush;
   logic            stkPop;
   logic            stkClr;
   logic            advance;

   assign pcInc    = pc + PC_W'(1);
   assign baseAddr = PC_W'(Base(
      32'(Bus.ProgSel) % NUM_PROGS, PROG_STRIDE));

   // Stack ops mirror the RUN priority chain below.
   always_comb begin
      advance = 1'b0;
      stkPush = 1'b0;
      stkPop  = 1'b0;
      advance = Reset && !Bus.Start && (state == RUN)
                && !Bus.Stall && !Bus.Halt;
      stkPop  = advance && Bus.Ret;
      stkPush = advance && !Bus.Ret && Bus.Call;
   end

   assign stkClr = !Reset || Bus.Start;

   ret_stack #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .Clk   (Clk),
      .push  (stkPush),
      .pop   (stkPop),
      .clr   (stkClr),
      .din   (pcInc),
      .dout  (stkTop),
      .full  (stkFull),
      .empty (stkEmpty)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= IDLE;
         pc       <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         stackErr <= 1'b0;
      end else if (Bus.Start) begin
         state    <= ARMED;
         pc       <= baseAddr;
         running  <= 1'b0;
         done     <= 1'b0;
         stackErr <= 1'b0;
      end else begin
         unique case (state)
            ARMED: begin
               state   <= RUN;
               running <= 1'b1;
            end
            RUN: begin
               if (!Bus.Stall) begin
                  priority case (1'b1)
                     Bus.Halt: begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                     end
                     Bus.Ret: begin
                        if (stkEmpty) begin
                           pc       <= pcInc;
                           stackErr <= 1'b1;
                        end else begin
                           pc <= stkTop;
                        end
                     end
                     Bus.Call: begin
                        pc <= Bus.TargetOrOffset;
                        if (stkFull) stackErr <= 1'b1;
                     end
                     Bus.BranchAbsEn:
                        pc <= Bus.TargetOrOffset;
                     Bus.BranchRelEn && Bus.ALU_flag:
                        pc <= pc + Bus.TargetOrOffset;
                     default:
                        pc <= pcInc;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign Bus.PC       = pc;
   assign Bus.Running  = running;
   assign Bus.Done     = done;
   assign Bus.StackErr = stackErr;
endmodule

// File: doc/prog_ctr_ret.md
# prog_ctr_ret

Parametrised successor to the existing program counter. It handles start/program selection, absolute branches, flag-qualified relative branches, call/return through a bounded hardware return stack, stall and halt. It sits in the instruction-fetch stage. Its registered PC output drives the instruction ROM address, and it takes branch/call/return controls from decode and the ALU flag from execute.

## Interface
- PC_W, 10: PC and TargetOrOffset width.
- STACK_DEPTH, 4: return-stack entries, ≥1.
- NUM_PROGS, 4: selectable programs, power of two.
- PROG_STRIDE, 256: program base spacing. Base(n) = n*PROG_STRIDE, truncated to PC_W.

Ports (one clock; reset is synchronous and active-low):
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  start/restart request.
- ProgSel  in  $clog2(NUM_PROGS)  program index, sampled while Start=1.
- BranchAbsEn  in  1  jump to TargetOrOffset.
- BranchRelEn  in  1  PC += signed TargetOrOffset when ALU_flag=1.
- ALU_flag  in  1  branch condition.
- Call  in  1  push PC+1, jump to TargetOrOffset.
- Ret  in  1  pop into PC.
- Stall  in  1  hold PC and stack this cycle.
- Halt  in  1  program finished.
- TargetOrOffset  in  PC_W  absolute target or two's-complement offset.
- PC  out  PC_W  registered instruction index.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- StackErr  out  1  sticky overflow/underflow flag; cleared by reset or by entering ARMED.

## Operation
- States:
  - IDLE, ARMED, RUN, DONE.
  - Reset → IDLE.
- Start=1 in any state → ARMED:
  - PC ← Base(ProgSel).
  - Stack pointer ← 0, StackErr ← 0.
  - Start=1 in RUN aborts the running program.
- ARMED, Start=1: stay, reload PC ← Base(ProgSel). The last sampled ProgSel wins.
- ARMED, Start=0 → RUN. PC unchanged, so the base instruction is fetched first.
- IDLE/DONE, Start=0: hold PC.
- RUN with Stall=1: no change to PC, stack or state. Stall overrides everything except Reset and Start.
- RUN with Stall=0, first match wins:
  1. Halt → DONE, PC held.
  2. Ret:
     - Stack non-empty: PC ← top, pop.
     - Stack empty: PC ← PC+1, StackErr ← 1.
  3. Call:
     - Stack not full: push PC+1, PC ← TargetOrOffset.
     - Stack full: still jump, no push (entry dropped), StackErr ← 1.
  4. BranchAbsEn → PC ← TargetOrOffset.
  5. BranchRelEn & ALU_flag → PC ← PC + sext(TargetOrOffset), mod 2^PC_W.
  6. Otherwise PC ← PC+1, mod 2^PC_W (wraps max → 0).
- BranchRelEn with ALU_flag=0 → PC+1.
- Branch/call/return inputs are ignored outside RUN.

## Timing
- Reset values: PC=0, Running=0, Done=0, StackErr=0, stack pointer=0, state IDLE.
- Reset has priority over Start.
- Single-cycle latency: inputs sampled at an edge determine PC immediately after that edge.
- No combinational input→output paths.
- Running and Done are decoded from registered state. They are valid the same cycle the state is entered.
- Push and pop complete in the same edge as the PC update. A Call followed next cycle by Ret returns to the call site +1.
- Reset asserted mid-RUN with a non-empty stack empties the stack at that edge.

## Structure
- prog_ctr_pkg holds:
  - the state enum (IDLE, ARMED, RUN, DONE);
  - default PC_W, STACK_DEPTH, NUM_PROGS, PROG_STRIDE;
  - the Base() function.
- Sub-module ret_stack is a parametrised LIFO. Its interface:
  - inputs: push, pop, clr, din;
  - outputs: dout, full, empty;
  - pointer width $clog2(STACK_DEPTH+1).
  - Its push/pop-when-full/empty guards are enforced inside the LIFO and reported to the parent.

## Test plan
- Reset low 1 cycle, then high → PC=0, Running=0, Done=0. Hold 2 cycles with no Start → PC stays 0.
- Start=1 with ProgSel=1 for 2 cycles → PC=256, state ARMED. Start=0 → Running=1, PC=256. Next cycle → PC=257.
- In RUN at PC=257:
  - BranchAbsEn, Target=10 → PC=10.
  - BranchRelEn, offset 5, flag 0 → PC=11.
  - BranchRelEn, offset 5, flag 1 → PC=16.
  - BranchRelEn, offset 0x3FE (−2), flag 1 → PC=14.
- At PC=20: Call, Target=100 → PC=100. Call, Target=200 → PC=200. Ret → PC=101. Ret → PC=21. StackErr=0.
- Overflow and underflow:
  - 5 consecutive Calls with STACK_DEPTH=4 → fifth call still jumps, StackErr=1.
  - After a fresh Start, Ret on empty stack at PC=30 → PC=31, StackErr=1.
- Boundaries:
  - Stall=1 with Call asserted → PC and stack unchanged.
  - PC=1023, no branch → PC=0.
  - Halt → Done=1, PC frozen; Start from DONE re-arms.
  - Reset mid-RUN → all outputs at reset values.
